// File: rtl/prefetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package prefetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_EXC_NONE     = 2'b00,
        FETCH_EXC_ACCESS   = 2'b01,
        FETCH_EXC_MISALIGN = 2'b10
    } fetch_exc_e;

    // Fetch control: IDLE only lasts until the first edge after reset.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_MISALIGN,
        ST_HALT
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/prefetch_unit_if.sv
// Memory request/response, redirect and decode handshake bundle of the fetch unit.
interface prefetch_unit_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [31:0]     imem_rsp_instr_i;
    logic            imem_rsp_err_i;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            dec_valid_o;
    logic            dec_ready_i;
    logic [31:0]     dec_instr_o;
    logic [XLEN-1:0] dec_pc_o;
    logic [1:0]      dec_exc_o;

    modport master (
        output imem_req_valid_o, imem_req_addr_o,
        output dec_valid_o, dec_instr_o, dec_pc_o, dec_exc_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_instr_i, imem_rsp_err_i,
        input  redirect_valid_i, redirect_pc_i, dec_ready_i
    );

    modport slave (
        input  imem_req_valid_o, imem_req_addr_o,
        input  dec_valid_o, dec_instr_o, dec_pc_o, dec_exc_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_instr_i, imem_rsp_err_i,
        output redirect_valid_i, redirect_pc_i, dec_ready_i
    );
endinterface

// File: rtl/prefetch_unit_instr_fifo.sv
// Synchronous prefetch queue with flush; head is registered so a push shows the next cycle.
module prefetch_unit_instr_fifo #(
    parameter int WIDTH = 98,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         nonempty,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    occ_q;
    logic             do_pop;

    assign do_pop    = pop && (occ_q != '0);
    assign rdata     = mem_q[rd_ptr_q];
    assign nonempty  = (occ_q != '0);
    assign occupancy = occ_q;

    // Flush wins over a same-cycle push or pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q <= occ_q + CW'(push) - CW'(do_pop);
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !flush && !do_pop && occ_q == CW'(DEPTH)));

endmodule

// File: rtl/prefetch_unit.sv
// Decoupled fetch front end: credit-limited in-order requests feeding a prefetch queue.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int              XLEN            = 64,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input logic             clk,
    input logic             reset_n,
    prefetch_unit_if.master bus
);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              EW      = 32 + XLEN + 2;
    localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, rsp_pc_q, mis_pc_q, hold_addr_q;
    logic [CW-1:0]   outst_q, outst_d, drop_q, occupancy;
    logic [CW:0]     credit;
    logic            hold_q, hold_stale_q, stale_req;
    logic            issue, req_valid, accept, rsp_keep, mis_push, push, pop;
    logic            redirect, nonempty;
    logic [EW-1:0]   wdata, rdata;

    assign redirect  = bus.redirect_valid_i;
    assign credit    = {1'b0, occupancy} + {1'b0, outst_q} - {1'b0, drop_q};
    assign req_valid = hold_q | issue;
    assign accept    = req_valid & bus.imem_req_ready_i;
    // A held request issued before a redirect still counts as a drop when it lands.
    assign stale_req = hold_q & hold_stale_q;
    assign rsp_keep  = bus.imem_rsp_valid_i & (drop_q == '0) & ~redirect;
    assign push      = rsp_keep | mis_push;
    assign pop       = nonempty & bus.dec_ready_i & ~redirect;
    assign outst_d   = outst_q + CW'(accept) - CW'(bus.imem_rsp_valid_i);

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        mis_push = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                issue = (outst_q < CW'(MAX_OUTSTANDING)) && (credit < DEPTH_C);
                if (rsp_keep && bus.imem_rsp_err_i) state_d = ST_HALT;
            end
            ST_MISALIGN: begin
                mis_push = (drop_q == '0);
                if (mis_push) state_d = ST_HALT;
            end
            default: state_d = state_q;
        endcase
        if (redirect) begin
            state_d  = bus.redirect_pc_i[1] ? ST_MISALIGN : ST_RUN;
            mis_push = 1'b0;
        end
    end

    always_comb begin
        wdata = {32'h0, mis_pc_q, FETCH_EXC_MISALIGN};
        if (rsp_keep) begin
            if (bus.imem_rsp_err_i) wdata = {32'h0, rsp_pc_q, FETCH_EXC_ACCESS};
            else                    wdata = {bus.imem_rsp_instr_i, rsp_pc_q, FETCH_EXC_NONE};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q   <= RESET_PC;
            rsp_pc_q     <= RESET_PC;
            mis_pc_q     <= '0;
            hold_addr_q  <= '0;
            outst_q      <= '0;
            drop_q       <= '0;
            hold_q       <= 1'b0;
            hold_stale_q <= 1'b0;
        end else begin
            outst_q      <= outst_d;
            hold_q       <= req_valid & ~bus.imem_req_ready_i;
            hold_stale_q <= req_valid & ~bus.imem_req_ready_i & (stale_req | redirect);
            hold_addr_q  <= bus.imem_req_addr_o;
            if (redirect) begin
                fetch_pc_q <= bus.redirect_pc_i & ~XLEN'(3);
                rsp_pc_q   <= bus.redirect_pc_i & ~XLEN'(3);
                mis_pc_q   <= bus.redirect_pc_i & ~XLEN'(1);
                drop_q     <= outst_d;
            end else begin
                if (accept && !stale_req) fetch_pc_q <= fetch_pc_q + STEP;
                if (rsp_keep)             rsp_pc_q   <= rsp_pc_q + STEP;
                drop_q <= drop_q - CW'(bus.imem_rsp_valid_i && drop_q != '0)
                                 + CW'(accept && stale_req);
            end
        end
    end

    prefetch_unit_instr_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .wdata     (wdata),
        .rdata     (rdata),
        .nonempty  (nonempty),
        .occupancy (occupancy)
    );

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_req_addr_o  = hold_q ? hold_addr_q : fetch_pc_q;
    assign bus.dec_valid_o      = nonempty;
    assign {bus.dec_instr_o, bus.dec_pc_o, bus.dec_exc_o} = rdata;

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit with an in-order memory model returning addr[31:0].
module tb_prefetch_unit;
    import prefetch_unit_pkg::*;

    typedef struct { logic [63:0] addr; int due; } mreq_t;
    typedef struct { logic [63:0] pc; logic [31:0] instr; logic [1:0] exc; } pop_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    prefetch_unit_if #(.XLEN(64)) bus ();

    prefetch_unit #(.XLEN(64), .RESET_PC(64'h0), .DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    mreq_t       mq[$];
    logic [63:0] req_log[$];
    pop_t        pop_log[$];
    int          cyc, vectors, errors, mem_lat;
    bit          mem_stall, rsp_hold, err_en;
    logic [63:0] err_addr;

    // One clock: log a pop, step the edge, then drive the memory side for the new cycle.
    task automatic cycle();
        pop_t  p;
        mreq_t m;
        if (bus.dec_valid_o && bus.dec_ready_i && !bus.redirect_valid_i) begin
            p.pc = bus.dec_pc_o; p.instr = bus.dec_instr_o; p.exc = bus.dec_exc_o;
            pop_log.push_back(p);
        end
        @(posedge clk); #1;
        cyc++;
        bus.redirect_valid_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_instr_i = 32'h0;
        bus.imem_rsp_err_i   = 1'b0;
        if (!rsp_hold && mq.size() != 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_instr_i = mq[0].addr[31:0];
            bus.imem_rsp_err_i   = err_en && (mq[0].addr == err_addr);
            mq.delete(0);
        end
        bus.imem_req_ready_i = !mem_stall;
        if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
            m.addr = bus.imem_req_addr_o; m.due = cyc + mem_lat;
            mq.push_back(m);
            req_log.push_back(bus.imem_req_addr_o);
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic hold_reset();
        reset_n = 1'b0;
        bus.imem_req_ready_i = 1'b0; bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_instr_i = 32'h0; bus.imem_rsp_err_i = 1'b0;
        bus.redirect_valid_i = 1'b0; bus.redirect_pc_i = 64'h0; bus.dec_ready_i = 1'b0;
        mem_stall = 0; rsp_hold = 0; err_en = 0; err_addr = 64'h0; mem_lat = 1; cyc = 0;
        mq.delete(); req_log.delete(); pop_log.delete();
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        hold_reset();
        reset_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = pc;
    endtask

    task automatic test_reset();
        hold_reset();
        vectors++; if (bus.imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", bus.imem_req_valid_o); end
        vectors++; if (bus.imem_req_addr_o !== 64'h0) begin errors++; $display("FAIL rst_req_addr got %h exp 0", bus.imem_req_addr_o); end
        vectors++; if (bus.dec_valid_o !== 1'b0) begin errors++; $display("FAIL rst_dec_valid got %b exp 0", bus.dec_valid_o); end
        vectors++; if ({bus.dec_instr_o, bus.dec_pc_o, bus.dec_exc_o} !== '0) begin errors++; $display("FAIL rst_dec_bus got %h/%h/%h exp 0", bus.dec_instr_o, bus.dec_pc_o, bus.dec_exc_o); end
        reset_n = 1'b1;
        #1;
        vectors++; if (bus.imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_release_valid got %b exp 0", bus.imem_req_valid_o); end
    endtask

    task automatic test_stream();
        apply_reset();
        bus.dec_ready_i = 1'b1;
        run(2);
        vectors++; if (bus.dec_valid_o !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %b exp 0", bus.dec_valid_o); end
        run(1);
        vectors++; if (bus.dec_valid_o !== 1'b1 || bus.dec_pc_o !== 64'h0) begin errors++; $display("FAIL stream_first got v=%b pc=%h exp v=1 pc=0", bus.dec_valid_o, bus.dec_pc_o); end
        run(7);
        vectors++; if (pop_log.size() != 7) begin errors++; $display("FAIL stream_pop_count got %0d exp 7", pop_log.size()); end
        for (int i = 0; i < pop_log.size(); i++) begin
            vectors++;
            if (pop_log[i].pc !== 64'(4*i) || pop_log[i].instr !== 32'(4*i) || pop_log[i].exc !== 2'b00) begin
                errors++; $display("FAIL stream_pop[%0d] got pc=%h instr=%h exc=%0d exp pc=%h", i, pop_log[i].pc, pop_log[i].instr, pop_log[i].exc, 4*i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (req_log.size() <= i || req_log[i] !== 64'(4*i)) begin errors++; $display("FAIL stream_req[%0d] exp %h", i, 4*i); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        run(20);
        vectors++; if (req_log.size() != 4) begin errors++; $display("FAIL bp_req_count got %0d exp 4", req_log.size()); end
        vectors++; if (bus.imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %b exp 0", bus.imem_req_valid_o); end
        vectors++; if (bus.dec_valid_o !== 1'b1 || bus.dec_pc_o !== 64'h0) begin errors++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=0", bus.dec_valid_o, bus.dec_pc_o); end
        bus.dec_ready_i = 1'b1;
        run(12);
        vectors++; if (pop_log.size() < 5) begin errors++; $display("FAIL bp_drain_count got %0d exp >=5", pop_log.size()); end
        for (int i = 0; i < pop_log.size(); i++) begin
            vectors++;
            if (pop_log[i].pc !== 64'(4*i)) begin errors++; $display("FAIL bp_drain[%0d] got %h exp %h", i, pop_log[i].pc, 4*i); end
        end
    endtask

    task automatic test_redirect_flush();
        apply_reset();
        run(3);
        rsp_hold = 1;
        run(2);
        vectors++; if (req_log.size() != 4 || mq.size() != 2) begin errors++; $display("FAIL rf_setup got req=%0d outstanding=%0d exp 4/2", req_log.size(), mq.size()); end
        vectors++; if (bus.imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rf_credit_valid got %b exp 0", bus.imem_req_valid_o); end
        redirect_to(64'h100);
        bus.dec_ready_i = 1'b1;
        run(1);
        rsp_hold = 0;
        vectors++; if (bus.dec_valid_o !== 1'b0) begin errors++; $display("FAIL rf_flushed got %b exp 0", bus.dec_valid_o); end
        run(10);
        vectors++; if (req_log.size() < 5 || req_log[4] !== 64'h100) begin errors++; $display("FAIL rf_next_req exp 100"); end
        vectors++; if (pop_log.size() < 2) begin errors++; $display("FAIL rf_pop_count got %0d exp >=2", pop_log.size()); end
        else begin
            vectors++; if (pop_log[0].pc !== 64'h100 || pop_log[0].instr !== 32'h100) begin errors++; $display("FAIL rf_pop0 got pc=%h instr=%h exp 100", pop_log[0].pc, pop_log[0].instr); end
            vectors++; if (pop_log[1].pc !== 64'h104) begin errors++; $display("FAIL rf_pop1 got %h exp 104", pop_log[1].pc); end
        end
    endtask

    task automatic test_stall_redirect();
        apply_reset();
        bus.dec_ready_i = 1'b1;
        run(2);
        mem_stall = 1;
        run(1);
        vectors++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 64'h8) begin errors++; $display("FAIL sr_pre got v=%b a=%h exp 1/8", bus.imem_req_valid_o, bus.imem_req_addr_o); end
        redirect_to(64'h200);
        for (int i = 0; i < 2; i++) begin
            run(1);
            vectors++; if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 64'h8) begin errors++; $display("FAIL sr_hold[%0d] got v=%b a=%h exp 1/8", i, bus.imem_req_valid_o, bus.imem_req_addr_o); end
        end
        mem_stall = 0;
        run(1);
        vectors++; if (req_log.size() != 3 || req_log[2] !== 64'h8) begin errors++; $display("FAIL sr_accept8 got size %0d exp 3 ending 8", req_log.size()); end
        run(8);
        vectors++; if (req_log.size() < 4 || req_log[3] !== 64'h200) begin errors++; $display("FAIL sr_next_req exp 200"); end
        vectors++; if (pop_log.size() == 0 || pop_log[0].pc !== 64'h200 || pop_log[0].instr !== 32'h200) begin errors++; $display("FAIL sr_first_pop exp pc=200 (pops=%0d)", pop_log.size()); end
    endtask

    task automatic test_access_fault();
        int n0;
        apply_reset();
        bus.dec_ready_i = 1'b1;
        err_en = 1; err_addr = 64'h40;
        run(25);
        vectors++; if (req_log.size() != 18 || req_log[17] !== 64'h44) begin errors++; $display("FAIL af_req_stop got size %0d exp 18 ending 44", req_log.size()); end
        vectors++; if (bus.imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL af_halt_valid got %b exp 0", bus.imem_req_valid_o); end
        vectors++; if (pop_log.size() < 17 || pop_log[16].pc !== 64'h40 || pop_log[16].instr !== 32'h0 || pop_log[16].exc !== 2'b01) begin errors++; $display("FAIL af_entry exp pc=40 instr=0 exc=1 (pops=%0d)", pop_log.size()); end
        n0 = pop_log.size();
        redirect_to(64'h80);
        run(8);
        vectors++; if (req_log.size() < 19 || req_log[18] !== 64'h80) begin errors++; $display("FAIL af_resume_req exp 80"); end
        vectors++; if (pop_log.size() <= n0 || pop_log[n0].pc !== 64'h80 || pop_log[n0].exc !== 2'b00) begin errors++; $display("FAIL af_resume_pop exp pc=80 exc=0"); end
    endtask

    task automatic test_misalign();
        int n_req, n_pop;
        apply_reset();
        bus.dec_ready_i = 1'b1;
        run(6);
        n_req = req_log.size();
        n_pop = pop_log.size();
        redirect_to(64'h102);
        run(12);
        vectors++; if (req_log.size() != n_req) begin errors++; $display("FAIL ma_no_req got %0d exp %0d", req_log.size(), n_req); end
        vectors++; if (pop_log.size() != n_pop + 1) begin errors++; $display("FAIL ma_pop_count got %0d exp %0d", pop_log.size(), n_pop + 1); end
        else begin
            vectors++; if (pop_log[n_pop].pc !== 64'h102 || pop_log[n_pop].instr !== 32'h0 || pop_log[n_pop].exc !== 2'b10) begin errors++; $display("FAIL ma_entry got pc=%h instr=%h exc=%0d exp 102/0/2", pop_log[n_pop].pc, pop_log[n_pop].instr, pop_log[n_pop].exc); end
        end
        vectors++; if (bus.imem_req_valid_o !== 1'b0 || bus.dec_valid_o !== 1'b0) begin errors++; $display("FAIL ma_halted got req=%b dec=%b exp 0/0", bus.imem_req_valid_o, bus.dec_valid_o); end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_stall_redirect();
        test_access_fault();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
